// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI slave receiver.
package spi_rx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int   DEFAULT_FRAME_BITS = 24;
  localparam logic CS_IDLE            = 1'b1;
  localparam logic SCK_IDLE           = 1'b1;
endpackage

// File: rtl/spi_rx_slave_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall strobes
// derived from the synchronised level and a one-cycle delayed copy.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain_p;
  logic                   prev_p;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      chain_p <= {SYNC_STAGES{RESET_VAL}};
      prev_p  <= RESET_VAL;
    end else begin
      chain_p <= {chain_p[SYNC_STAGES-2:0], async_in};
      prev_p  <= chain_p[SYNC_STAGES-1];
    end
  end

  assign sync = chain_p[SYNC_STAGES-1];
  assign rise = sync & ~prev_p;
  assign fall = ~sync & prev_p;
endmodule

// File: rtl/spi_rx_slave.sv
// SPI slave receiver (CS low, SCK idles high, sample on SCK fall, MSB first).
// Define SPI_RX_MISO_EN to add a MISO port that echoes the previous valid word.
module spi_rx_slave
  import spi_rx_pkg::*;
#(
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  spi_cs_in,
  input  logic                  spi_clock_in,
  input  logic                  spi_data_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  busy
`ifdef SPI_RX_MISO_EN
  ,
  output logic                  spi_data_out
`endif
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic cs_s, cs_rise, cs_fall, sck_fall, mosi_s, sck_take;
  logic sck_level_unused;
  logic [1:0] mosi_edge_unused;
`ifdef SPI_RX_MISO_EN
  logic sck_rise;
  logic [FRAME_BITS-1:0] tx_q, tx_nxt;
`else
  logic sck_rise_unused;
`endif

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs_sync (
    .clock_in(clock_in), .reset_n(reset_n), .async_in(spi_cs_in),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
    .clock_in(clock_in), .reset_n(reset_n), .async_in(spi_clock_in),
    .sync(sck_level_unused),
`ifdef SPI_RX_MISO_EN
    .rise(sck_rise),
`else
    .rise(sck_rise_unused),
`endif
    .fall(sck_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clock_in(clock_in), .reset_n(reset_n), .async_in(spi_data_in),
    .sync(mosi_s), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
  );

  assign sck_take = sck_fall & ~cs_s;

  state_t                 state_q, state_nxt;
  logic [FRAME_BITS-1:0]  shift_q, shift_nxt, data_nxt;
  logic [CNT_W-1:0]       count_q, count_nxt;
  logic                   over_q, over_nxt, dv_nxt, fe_nxt;
  logic                   armed_q;
  logic [SYNC_STAGES-1:0] settle_p;

  // The synchroniser's reset level is not a real observation of CS, so arming
  // waits until the chain has been refilled with genuine samples.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      settle_p <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_p <= {settle_p[SYNC_STAGES-2:0], 1'b1};
      armed_q  <= armed_q | (cs_s & settle_p[SYNC_STAGES-1]);
    end
  end

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    count_nxt = count_q;
    over_nxt  = over_q;
    data_nxt  = data_out;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
`ifdef SPI_RX_MISO_EN
    tx_nxt    = tx_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_nxt = SHIFT;
          shift_nxt = '0;
          count_nxt = '0;
          over_nxt  = 1'b0;
`ifdef SPI_RX_MISO_EN
          tx_nxt    = data_out;
`endif
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          fe_nxt    = (count_q != '0);
          state_nxt = IDLE;
        end else if (sck_take) begin
          shift_nxt = {shift_q[FRAME_BITS-2:0], mosi_s};
          count_nxt = count_q + 1'b1;
          if (count_q == LAST_BIT) state_nxt = FULL;
        end
`ifdef SPI_RX_MISO_EN
        else if (sck_rise) begin
          tx_nxt = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
`endif
      end
      FULL: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          if (over_q) begin
            fe_nxt = 1'b1;
          end else begin
            data_nxt = shift_q;
            dv_nxt   = 1'b1;
          end
        end else if (sck_take) begin
          over_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      over_q      <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
`ifdef SPI_RX_MISO_EN
      tx_q        <= '0;
`endif
    end else begin
      state_q     <= state_nxt;
      shift_q     <= shift_nxt;
      count_q     <= count_nxt;
      over_q      <= over_nxt;
      data_out    <= data_nxt;
      data_valid  <= dv_nxt;
      frame_error <= fe_nxt;
`ifdef SPI_RX_MISO_EN
      tx_q        <= tx_nxt;
`endif
    end
  end

  assign busy = (state_q != IDLE);
`ifdef SPI_RX_MISO_EN
  assign spi_data_out = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
`endif
endmodule

// File: tb/tb_spi_rx_slave.sv
// Bench for spi_rx_slave: vector table, corner-case sequences and random frames
// checked against a frame-level model. Honours SPI_RX_MISO_EN when defined.
module tb_spi_rx_slave;
  localparam int FB   = 24;
  localparam int SYNC = 2;
  localparam int HALF = 10;

  logic          clock_in = 1'b0;
  logic          reset_n, spi_cs_in, spi_clock_in, spi_data_in;
  logic [FB-1:0] data_out;
  logic          data_valid, frame_error, busy, miso;

  spi_rx_slave #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .spi_cs_in(spi_cs_in),
    .spi_clock_in(spi_clock_in), .spi_data_in(spi_data_in),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
`ifdef SPI_RX_MISO_EN
    .spi_data_out(miso),
`endif
    .busy(busy)
  );
`ifndef SPI_RX_MISO_EN
  assign miso = 1'b0;
`endif

  always #5 clock_in = ~clock_in;

  int n_checks = 0, n_pass = 0;
  int dv_cnt = 0, fe_cnt = 0, overlap = 0;
  logic [FB-1:0] dv_q[$];
  logic [FB-1:0] exp_data;

  always @(negedge clock_in) begin
    if (data_valid) begin
      dv_cnt++;
      dv_q.push_back(data_out);
    end
    if (frame_error) fe_cnt++;
    if (data_valid && frame_error) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b, output logic m);
    spi_data_in = b;
    repeat (HALF) @(negedge clock_in);
    m = miso;
    spi_clock_in = 1'b0;
    repeat (HALF) @(negedge clock_in);
    spi_clock_in = 1'b1;
  endtask

  // Full frame of n bits (MSB of the n-bit field first); returns with CS just raised.
  task automatic run_frame(input logic [31:0] w, input int n, output logic [31:0] rd);
    logic m;
    rd = '0;
    @(negedge clock_in);
    spi_cs_in = 1'b0;
    repeat (HALF) @(negedge clock_in);
    for (int i = 0; i < n; i++) begin
      send_bit(w[n-1-i], m);
      rd = {rd[30:0], m};
    end
    repeat (HALF) @(negedge clock_in);
    spi_cs_in = 1'b1;
  endtask

  task automatic settle();
    repeat (SYNC + 4) @(negedge clock_in);
  endtask

  task automatic frame_and_check(input string name, input logic [31:0] w, input int n,
                                 input int exp_dv, input int exp_fe, input logic [FB-1:0] exp_d);
    int dv0, fe0;
    logic [31:0] rd;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    run_frame(w, n, rd);
    settle();
    check({name, ".dv"}, dv_cnt - dv0, exp_dv);
    check({name, ".fe"}, fe_cnt - fe0, exp_fe);
    check({name, ".data"}, data_out, exp_d);
    check({name, ".busy"}, busy, 0);
  endtask

  typedef struct {
    logic [31:0]   word;
    int            nbits;
    int            exp_dv;
    int            exp_fe;
    logic [FB-1:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    logic        m;
    int          dv0, fe0, n, edv, efe;
    logic [31:0] w;

    vecs[0] = '{32'h00A5C33C, 24, 1, 0, 24'hA5C33C};
    vecs[1] = '{32'h000002AB, 10, 0, 1, 24'hA5C33C};
    vecs[2] = '{32'h01FFFFFF, 25, 0, 1, 24'hA5C33C};
    vecs[3] = '{32'h00000001, 24, 1, 0, 24'h000001};
    vecs[4] = '{32'h00000000,  0, 0, 0, 24'h000001};
    vecs[5] = '{32'h00123456, 24, 1, 0, 24'h123456};
    vecs[6] = '{32'h00000155,  1, 0, 1, 24'h123456};

    reset_n = 1'b0; spi_cs_in = 1'b1; spi_clock_in = 1'b1; spi_data_in = 1'b0;
    repeat (3) @(negedge clock_in);
    check("rst.data", data_out, 0);
    check("rst.dv", data_valid, 0);
    check("rst.fe", frame_error, 0);
    check("rst.busy", busy, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock_in);

    for (int i = 0; i < 7; i++)
      frame_and_check($sformatf("vec%0d", i), vecs[i].word, vecs[i].nbits,
                      vecs[i].exp_dv, vecs[i].exp_fe, vecs[i].exp_data);

    // CS pulse without SCK: busy only while selected, no pulses
    dv0 = dv_cnt; fe0 = fe_cnt;
    spi_cs_in = 1'b0;
    repeat (6) @(negedge clock_in);
    check("empty.busy_hi", busy, 1);
    spi_cs_in = 1'b1;
    settle();
    check("empty.busy_lo", busy, 0);
    check("empty.pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);

    // Reset in the middle of a frame: rest of the frame must be ignored
    dv0 = dv_cnt; fe0 = fe_cnt;
    w = 32'h000F0F0F;
    spi_cs_in = 1'b0;
    repeat (HALF) @(negedge clock_in);
    for (int i = 0; i < 12; i++) send_bit(w[23-i], m);
    reset_n = 1'b0;
    #1;
    check("midrst.data", data_out, 0);
    check("midrst.busy", busy, 0);
    check("midrst.dv_fe", {data_valid, frame_error}, 0);
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    for (int i = 12; i < 24; i++) send_bit(w[23-i], m);
    repeat (HALF) @(negedge clock_in);
    spi_cs_in = 1'b1;
    settle();
    check("midrst.pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
    check("midrst.idle", busy, 0);

    // Exact output latency after CS rises
    run_frame(32'h00FFFFFF, 24, rd);
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(negedge clock_in);
      check($sformatf("lat.dv%0d", k), data_valid, (k == SYNC + 1));
    end
    check("lat.busy", busy, 0);
    settle();
    check("lat.data", data_out, 24'hFFFFFF);

    // Back-to-back frames with CS high for two cycles
    dv_q.delete();
    run_frame(32'h00123456, 24, rd);
    @(negedge clock_in);
    run_frame(32'h00654321, 24, rd);
    settle();
    check("b2b.count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      check("b2b.first", dv_q[0], 24'h123456);
      check("b2b.second", dv_q[1], 24'h654321);
    end
`ifdef SPI_RX_MISO_EN
    check("miso.readback", rd, 32'h00123456);
    check("miso.idle", miso, 0);
    run_frame(32'h00ABCDEF, 24, rd);
    settle();
    check("miso.readback2", rd, 32'h00654321);
    check("miso.idle2", miso, 0);
    exp_data = 24'hABCDEF;
`else
    exp_data = 24'h654321;
`endif

    // Random frames against a frame-level model
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r == 0)      n = 0;
      else if (r <= 2) n = $urandom_range(1, FB - 1);
      else if (r == 3) n = $urandom_range(FB + 1, FB + 3);
      else             n = FB;
      if (n < 32) w = w & ((32'h1 << n) - 1);
      edv = (n == FB) ? 1 : 0;
      efe = (n != 0 && n != FB) ? 1 : 0;
      if (edv == 1) exp_data = w[FB-1:0];
      frame_and_check($sformatf("rnd%0d_n%0d", t, n), w, n, edv, efe, exp_data);
    end

    check("dv_fe_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
